// File: rtl/grant_arb_pkg.sv
// rtl/grant_arb_pkg.sv - shared constants and beat classification for grant_locking_rr_arbiter
//
// Contents:
//   GNT_PUT_DATA  built-in grant type that carries a multi-beat data message
//   GNT_DATA      non-built-in grant type that carries a multi-beat data message
//   STAT_W        width of each per-channel completion counter
//   is_multibeat  classifies a beat from its is_builtin flag and g_type
package grant_arb_pkg;

    localparam logic [3:0] GNT_PUT_DATA = 4'h5;
    localparam logic [3:0] GNT_DATA     = 4'h0;
    localparam int         STAT_W       = 16;

    function automatic logic is_multibeat(input logic is_builtin, input logic [3:0] g_type);
        return (is_builtin && (g_type == GNT_PUT_DATA)) ||
               (!is_builtin && (g_type == GNT_DATA));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - cyclic priority pick starting after the last granted channel
//
// Parameters:
//   N_IN   number of channels
//   SEL_W  width of the channel index
// Ports:
//   valid       per-channel request vector
//   last_grant  channel granted most recently; the scan starts one past it
//   index       first valid channel in cyclic order, or N_IN-1 when none is valid
module rr_pick #(
    parameter int N_IN  = 2,
    parameter int SEL_W = 1
) (
    input  logic [N_IN-1:0]  valid,
    input  logic [SEL_W-1:0] last_grant,
    output logic [SEL_W-1:0] index
);

    // Walk the cyclic order from farthest to nearest so the nearest valid
    // channel after last_grant is the final (winning) assignment.
    always_comb begin
        index = SEL_W'(N_IN - 1);
        for (int k = N_IN; k >= 1; k--) begin
            if (valid[(int'(last_grant) + k) % N_IN]) begin
                index = SEL_W'((int'(last_grant) + k) % N_IN);
            end
        end
    end

endmodule

// File: rtl/grant_locking_rr_arbiter.sv
// rtl/grant_locking_rr_arbiter.sv - round-robin grant arbiter that locks onto multi-beat messages
//
// Optional feature macro: GRANT_ARB_STATS_EN (per-channel completion counters)
//
// Parameters:
//   N_IN       number of input channels (2..8)
//   PAYLOAD_W  opaque payload width, passed through unmodified
//   BEATS      beats per multi-beat message (power of two, 2..16)
// Ports:
//   clk, reset                    clock; synchronous active-high reset
//   in_valid/in_ready             per-channel handshake
//   in_is_builtin/in_g_type       per-channel beat type (g_type of channel i at [4i+3:4i])
//   in_payload                    per-channel payload (channel i at [PAYLOAD_W*i +: PAYLOAD_W])
//   out_valid/out_ready           output handshake
//   out_is_builtin/out_g_type/out_payload  fields of the routed channel
//   out_chosen                    index of the routed channel
//   out_locked                    a multi-beat message is in progress
//   stat_clr, stat_grant_cnt      (GRANT_ARB_STATS_EN only) clear and 16-bit saturating
//                                 per-channel message completion counts
module grant_locking_rr_arbiter
    import grant_arb_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int PAYLOAD_W = 70,
    parameter int BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_IN-1:0]           in_valid,
    output logic [N_IN-1:0]           in_ready,
    input  logic [N_IN-1:0]           in_is_builtin,
    input  logic [4*N_IN-1:0]         in_g_type,
    input  logic [PAYLOAD_W*N_IN-1:0] in_payload,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_is_builtin,
    output logic [3:0]                out_g_type,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] out_chosen,
    output logic                      out_locked
`ifdef GRANT_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [STAT_W*N_IN-1:0]    stat_grant_cnt
`endif
);

    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0] beat_cnt;
    logic [SEL_W-1:0] lock_id;
    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] pick_idx;
    logic             fire;
    logic             multibeat;

    rr_pick #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_pick (
        .valid      (in_valid),
        .last_grant (last_grant),
        .index      (pick_idx)
    );

    assign out_locked = (beat_cnt != '0);
    assign out_chosen = out_locked ? lock_id : pick_idx;

    assign out_valid      = in_valid[out_chosen];
    assign out_is_builtin = in_is_builtin[out_chosen];
    assign out_g_type     = in_g_type[int'(out_chosen)*4 +: 4];
    assign out_payload    = in_payload[int'(out_chosen)*PAYLOAD_W +: PAYLOAD_W];

    assign fire      = out_valid && out_ready;
    assign multibeat = is_multibeat(out_is_builtin, out_g_type);

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = out_ready && (out_chosen == SEL_W'(i));
        end
    end

    // beat_cnt is CNT_W bits wide and BEATS is a power of two, so the
    // increment wraps from BEATS-1 to 0 on its own, releasing the lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt   <= '0;
            lock_id    <= '0;
            last_grant <= SEL_W'(N_IN - 1);
        end else if (fire) begin
            last_grant <= out_chosen;
            if (multibeat) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == '0) begin
                    lock_id <= out_chosen;
                end
            end
        end
    end

`ifdef GRANT_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [N_IN];
    logic              completion;

    // A message completes on any single-beat fire or on the last beat of a
    // multi-beat message.
    assign completion = fire && (!multibeat || (beat_cnt == CNT_W'(BEATS - 1)));

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (reset || stat_clr) begin
                stat_cnt[i] <= '0;
            end else if (completion && (out_chosen == SEL_W'(i)) && (stat_cnt[i] != '1)) begin
                stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_grant_cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            stat_grant_cnt[i*STAT_W +: STAT_W] = stat_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_grant_locking_rr_arbiter.sv
// tb/tb_grant_locking_rr_arbiter.sv - self-checking bench for grant_locking_rr_arbiter
module tb_grant_locking_rr_arbiter;

    localparam int N     = 2;
    localparam int PW    = 70;
    localparam int BEATS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      in_valid, in_ready, in_is_builtin;
    logic [4*N-1:0]    in_g_type;
    logic [PW*N-1:0]   in_payload;
    logic              out_valid, out_ready, out_is_builtin, out_locked;
    logic [3:0]        out_g_type;
    logic [PW-1:0]     out_payload;
    logic [0:0]        out_chosen;

    logic [3:0]        v4, r4;
    logic              ov4, ob4, ol4;
    logic [3:0]        og4;
    logic [7:0]        op4;
    logic [1:0]        oc4;
    logic              ready4;

`ifdef GRANT_ARB_STATS_EN
    logic              stat_clr;
    logic [16*N-1:0]   stat_grant_cnt;
    logic [63:0]       stat_cnt4;
`endif

    grant_locking_rr_arbiter #(.N_IN(N), .PAYLOAD_W(PW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_builtin(in_is_builtin),
        .in_g_type(in_g_type), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_builtin(out_is_builtin),
        .out_g_type(out_g_type), .out_payload(out_payload),
        .out_chosen(out_chosen), .out_locked(out_locked)
`ifdef GRANT_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_grant_cnt(stat_grant_cnt)
`endif
    );

    grant_locking_rr_arbiter #(.N_IN(4), .PAYLOAD_W(8), .BEATS(BEATS)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(v4), .in_ready(r4), .in_is_builtin(4'b0000),
        .in_g_type(16'h1111), .in_payload(32'h44332211),
        .out_valid(ov4), .out_ready(ready4), .out_is_builtin(ob4),
        .out_g_type(og4), .out_payload(op4),
        .out_chosen(oc4), .out_locked(ol4)
`ifdef GRANT_ARB_STATS_EN
        , .stat_clr(1'b0), .stat_grant_cnt(stat_cnt4)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: last granted channel, lock owner, and how many beats
    // of the current multi-beat message have gone by.
    int m_last = N - 1;
    int m_lock = 0;
    int m_done = 0;
    int grant_log[$];

    function automatic bit spec_multibeat(input logic b, input logic [3:0] t);
        return (b && t == 4'h5) || (!b && t == 4'h0);
    endfunction

    function automatic int model_pick(input logic [N-1:0] v);
        if (m_done != 0) return m_lock;
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return N - 1;
    endfunction

    always @(posedge clk) begin
        int c;
        c = model_pick(in_valid);
        if (reset) begin
            m_last = N - 1;
            m_lock = 0;
            m_done = 0;
        end else if (in_valid[c] && out_ready) begin
            grant_log.push_back(c);
            if (spec_multibeat(in_is_builtin[c], in_g_type[c*4 +: 4])) begin
                if (m_done == 0) m_lock = c;
                m_done = (m_done + 1) % BEATS;
            end
            m_last = c;
        end
    end

    always @(negedge clk) begin
        int c;
        if (started) begin
            c = model_pick(in_valid);
            check("chosen", 128'(out_chosen), 128'(c));
            check("out_valid", 128'(out_valid), 128'(in_valid[c]));
            check("out_locked", 128'(out_locked), 128'(m_done != 0));
            check("in_ready", 128'(in_ready), out_ready ? 128'(1 << c) : 128'(0));
            check("out_payload", 128'(out_payload), 128'(in_payload[c*PW +: PW]));
            check("out_g_type", 128'(out_g_type), 128'(in_g_type[c*4 +: 4]));
            check("out_is_builtin", 128'(out_is_builtin), 128'(in_is_builtin[c]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = '0;
        in_is_builtin = '0;
        in_g_type     = 8'h11;
        in_payload    = {6'h3F, 64'hFEDC_BA98_7654_3210, 6'h01, 64'h0123_4567_89AB_CDEF};
        out_ready     = 1'b0;
        v4            = '0;
        ready4        = 1'b0;
`ifdef GRANT_ARB_STATS_EN
        stat_clr      = 1'b0;
`endif
        step(3);
        reset   = 1'b0;
        started = 1'b1;
        step(1);

        // Reset state: unlocked, idle pick is the last channel.
        check("rst_locked", 128'(out_locked), 128'd0);
        check("rst_chosen", 128'(out_chosen), 128'd1);
        check("rst_valid", 128'(out_valid), 128'd0);

        // Two single-beat requesters alternate.
        grant_log.delete();
        in_valid  = 2'b11;
        out_ready = 1'b1;
        step(4);
        check("alt_n", 128'(grant_log.size()), 128'd4);
        if (grant_log.size() == 4) begin
            check("alt_0", 128'(grant_log[0]), 128'd0);
            check("alt_1", 128'(grant_log[1]), 128'd1);
            check("alt_2", 128'(grant_log[2]), 128'd0);
            check("alt_3", 128'(grant_log[3]), 128'd1);
        end

        // ch0 multi-beat put while ch1 stays valid.
        grant_log.delete();
        in_is_builtin = 2'b01;
        in_g_type     = 8'h15;
        step(1);
        check("mb_lock_b1", 128'(out_locked), 128'd1);
        check("mb_chosen_b1", 128'(out_chosen), 128'd0);
        step(6);
        check("mb_lock_b7", 128'(out_locked), 128'd1);
        step(1);
        check("mb_unlock", 128'(out_locked), 128'd0);
        check("mb_next", 128'(out_chosen), 128'd1);
        step(1);
        check("mb_n", 128'(grant_log.size()), 128'd9);
        for (int i = 0; i < 9 && i < grant_log.size(); i++) begin
            check("mb_seq", 128'(grant_log[i]), (i < 8) ? 128'd0 : 128'd1);
        end

        // Lock on ch1 (non-builtin GNT_DATA), then stall out_ready.
        in_is_builtin = 2'b00;
        in_g_type     = 8'h01;
        in_valid      = 2'b10;
        step(1);
        check("l1_locked", 128'(out_locked), 128'd1);
        in_valid  = 2'b11;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_ready", 128'(in_ready), 128'd0);
            check("stall_chosen", 128'(out_chosen), 128'd1);
        end
        // Valid drop while locked, then a single-beat beat from the owner.
        out_ready = 1'b1;
        in_valid  = 2'b01;
        step(2);
        check("drop_locked", 128'(out_locked), 128'd1);
        in_valid  = 2'b11;
        in_g_type = 8'h11;
        step(1);
        check("single_in_lock", 128'(out_locked), 128'd1);
        in_g_type = 8'h01;
        step(6);
        check("l1_b7", 128'(out_locked), 128'd1);
        step(1);
        check("l1_unlock", 128'(out_locked), 128'd0);

        // Reset after 3 of 8 beats on ch0.
        in_is_builtin = 2'b01;
        in_g_type     = 8'h15;
        step(3);
        check("pre_rst_locked", 128'(out_locked), 128'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_locked", 128'(out_locked), 128'd0);
        check("mid_rst_chosen", 128'(out_chosen), 128'd0);
        in_g_type = 8'h11;

`ifdef GRANT_ARB_STATS_EN
        stat_clr = 1'b1;
        in_valid = 2'b01;
        step(1);
        stat_clr = 1'b0;
        step(65537);
        check("stat_sat", 128'(stat_grant_cnt[15:0]), 128'hFFFF);
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        check("stat_clr", 128'(stat_grant_cnt[15:0]), 128'd0);
`endif

        // Four-channel pick after last_grant=2.
        out_ready = 1'b0;
        in_valid  = 2'b00;
        ready4    = 1'b1;
        v4        = 4'b0100;
        step(1);
        ready4 = 1'b0;
        v4     = 4'b0011;
        #1;
        check("n4_chosen", 128'(oc4), 128'd0);
        check("n4_valid", 128'(ov4), 128'd1);
        v4 = 4'b0000;
        #1;
        check("n4_idle_chosen", 128'(oc4), 128'd3);
        check("n4_idle_valid", 128'(ov4), 128'd0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grant_locking_rr_arbiter.md
GRANT_LOCKING_RR_ARBITER -- requirements
Module: grant_locking_rr_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 2: number of input channels, legal range 2..8.
REQ-002 SHALL have parameter PAYLOAD_W, default 70: opaque payload width (addr_beat, xact ids, data), passed through unmodified.
REQ-003 SHALL have parameter BEATS, default 8: beats per multi-beat message, a power of two, range 2..16.
REQ-004 SHALL have derived localparam SEL_W = max(1, clog2(N_IN)).
REQ-005 SHALL have port clk, input, 1: clock. reset, input, 1: reset, synchronous, active-high; clock clk.
REQ-006 SHALL have port in_valid, input, N_IN: per-channel valid.
REQ-007 SHALL have port in_ready, output, N_IN: per-channel ready.
REQ-008 SHALL have port in_is_builtin, input, N_IN: per-channel built-in-type flag.
REQ-009 SHALL have port in_g_type, input, 4*N_IN: per-channel grant type, channel i at [4i+3:4i].
REQ-010 SHALL have port in_payload, input, PAYLOAD_W*N_IN: per-channel payload.
REQ-011 SHALL have port out_valid, output, 1; out_ready, input, 1; out_is_builtin, output, 1; out_g_type, output, 4; out_payload, output, PAYLOAD_W.
REQ-012 SHALL have port out_chosen, output, SEL_W: index of the channel currently routed.
REQ-013 SHALL have port out_locked, output, 1: a multi-beat message is in progress.

Function
REQ-014 SHALL route all out_* fields combinationally from channel out_chosen, with zero cycles of latency.
REQ-015 SHALL treat a beat as multi-beat when (is_builtin && g_type==GNT_PUT_DATA(4'h5)) || (!is_builtin && g_type==GNT_DATA(4'h0)).
REQ-016 SHALL define fire = out_valid && out_ready.
REQ-017 SHALL, when unlocked, set out_chosen to the first valid channel scanning last_grant+1 .. N_IN-1, then 0 .. last_grant; when no channel is valid, out_chosen = N_IN-1.
REQ-018 SHALL, when locked, force out_chosen = lock_id regardless of other valids.
REQ-019 SHALL drive in_ready[i] = out_ready && (i == out_chosen), so that at most one ready bit is high.
REQ-020 SHALL load last_grant <= out_chosen on every fire.
REQ-021 SHALL, on a fire of a multi-beat beat, increment beat_cnt modulo BEATS, and load lock_id <= out_chosen when beat_cnt==0.
REQ-022 SHALL compute out_locked = (beat_cnt != 0); the lock releases in the cycle after the fire that wraps beat_cnt from BEATS-1 to 0.
REQ-023 SHALL not advance beat_cnt on a single-beat fire; while locked, a single-beat beat from lock_id fires normally without changing beat_cnt.
REQ-024 SHALL leave all state unchanged, with no lock release, when out_valid drops while locked.

Reset
REQ-025 SHALL on reset set beat_cnt=0, lock_id=0, last_grant=N_IN-1 (channel 0 has first priority), and clear statistics counters; reset overrides a simultaneous fire.
REQ-026 SHALL abandon any partial message when reset is asserted mid-message; in the cycle after reset, out_locked=0.

Configuration
REQ-027 SHALL, with GRANT_ARB_STATS_EN defined, add ports stat_clr (input, 1) and stat_grant_cnt (output, 16*N_IN): per-channel 16-bit saturating counts of message completions, where a completion is a single-beat fire or the final beat; stat_clr zeroes the counts and takes priority over a same-cycle increment.
REQ-028 SHALL, without GRANT_ARB_STATS_EN, have neither these ports nor the counters; all other behaviour is identical.

Structure
REQ-029 SHALL place GNT_PUT_DATA, GNT_DATA, the 16-bit stat width, and the is_multibeat function in shared package grant_arb_pkg.
REQ-030 SHALL implement the cyclic priority pick as sub-module rr_pick (inputs: valid vector and last_grant; output: index).

Verification
REQ-031 SHALL cover: after reset, in_valid=2'b11, single-beat beats, out_ready=1 -> grants alternate 0,1,0,1.
REQ-032 SHALL cover: ch0 sends a multi-beat beat (builtin, g_type=5, BEATS=8) while ch1 is valid throughout -> ch0 is granted 8 consecutive fires, out_locked is high for beats 2..8, and ch1 is granted next.
REQ-033 SHALL cover: locked on ch1 with out_ready=0 for 5 cycles -> no fire, beat_cnt is held, in_ready=0.
REQ-034 SHALL cover: N_IN=4, last_grant=2, valids=4'b0011 -> out_chosen=0; valids=0 -> out_chosen=3, out_valid=0.
REQ-035 SHALL cover: reset asserted after 3 of 8 beats -> out_locked=0 and last_grant=N_IN-1 in the next cycle.
REQ-036 SHALL cover, with GRANT_ARB_STATS_EN: 65537 single-beat completions on ch0 -> count=16'hFFFF; stat_clr together with a fire -> count=0.
